// File: rtl/mem_arb.sv
// mem_arb -- two-port arbiter in front of a simple strobed memory controller.
//
// Each port raises reqN with a command (wrN, addrN, wdataN). The arbiter
// picks one winner while idle, latches its command, walks the controller
// through SETUP -> STROBE (STROBE_CYC cycles) -> RELEASE, then pulses ackN
// for one cycle in DONE. Read data is captured into the owner's rdataN.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous active-high reset
//   prio                0 = round-robin, 1 = port 1 wins contention
//   req0/req1           access request per port
//   wr0/wr1             1 = write, 0 = read
//   addr0/addr1         access address (ADDR_W)
//   wdata0/wdata1       write data (DATA_W)
//   ack0/ack1           one-cycle completion pulse
//   rdata0/rdata1       read data, valid when ackN = 1, held until next read
//   busy                high whenever the arbiter is not idle
//   m_addr, m_idata     controller address / write data
//   m_csb, m_web, m_oeb controller strobes, active-low
//   m_ce                controller enable strobe, active-high
//   m_odata             read data returned by the controller
module mem_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prio,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_idata,
    output logic              m_csb,
    output logic              m_web,
    output logic              m_oeb,
    output logic              m_ce,
    input  logic [DATA_W-1:0] m_odata
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        DONE
    } state_t;

    state_t            state;
    logic              owner;       // port that owns the access in flight
    logic              last_grant;  // port granted most recently
    logic              cmd_wr;      // latched direction of the access in flight
    logic [1:0]        cnt;         // remaining STROBE cycles minus one

    // Winner selection, evaluated only while idle.
    logic              grant;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // NOTE: every output of a combinational block gets a value on every path;
    // the defaults at the top keep this block free of inferred latches.
    always_comb begin
        grant = req1;
        if (req0 && req1) begin
            grant = prio ? 1'b1 : ~last_grant;
        end
        win_wr    = grant ? wr1    : wr0;
        win_addr  = grant ? addr1  : addr0;
        win_wdata = grant ? wdata1 : wdata0;
    end

    // Address and write data are latched straight into m_addr / m_idata,
    // which then serve as the held command for the rest of the access.
    // NOTE: state and registered outputs use non-blocking assignments so all
    // of them update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cmd_wr     <= 1'b0;
            cnt        <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy       <= 1'b0;
            m_addr     <= '0;
            m_idata    <= '0;
            m_csb      <= 1'b1;
            m_web      <= 1'b1;
            m_oeb      <= 1'b1;
            m_ce       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state      <= SETUP;
                        busy       <= 1'b1;
                        owner      <= grant;
                        last_grant <= grant;
                        cmd_wr     <= win_wr;
                        m_addr     <= win_addr;
                        m_idata    <= win_wr ? win_wdata : '0;
                        m_csb      <= 1'b0;
                        m_web      <= ~win_wr;
                        m_oeb      <= win_wr;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    m_ce  <= 1'b1;
                    cnt   <= 2'(STROBE_CYC - 1);
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state   <= RELEASE;
                        m_ce    <= 1'b0;
                        m_csb   <= 1'b1;
                        m_web   <= 1'b1;
                        m_idata <= '0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RELEASE: begin
                    // Output enable was held through RELEASE so the controller
                    // still drives m_odata on the capturing edge.
                    state <= DONE;
                    m_oeb <= 1'b1;
                    if (!cmd_wr) begin
                        if (owner) rdata1 <= m_odata;
                        else       rdata0 <= m_odata;
                    end
                    ack0 <= ~owner;
                    ack1 <= owner;
                end
                DONE: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb. Two instances (STROBE_CYC = 1 and 3) share
// one stimulus stream; each has its own memory model and a transaction-level
// reference model that tracks the access phase since the grant.
module tb_mem_arb;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NI = 2;

    function automatic int sc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prio = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic          wr0 = 1'b0;
    logic          wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic [DW-1:0] wdata1 = '0;

    logic          ack0 [NI];
    logic          ack1 [NI];
    logic          busy [NI];
    logic          m_csb [NI];
    logic          m_web [NI];
    logic          m_oeb [NI];
    logic          m_ce [NI];
    logic [DW-1:0] rdata0 [NI];
    logic [DW-1:0] rdata1 [NI];
    logic [DW-1:0] m_idata [NI];
    logic [DW-1:0] m_odata [NI];
    logic [AW-1:0] m_addr [NI];

    logic [DW-1:0] mem [NI][65536];
    logic [DW-1:0] ref_mem [NI][65536];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arb #(
            .ADDR_W(AW),
            .DATA_W(DW),
            .STROBE_CYC((g == 0) ? 1 : 3)
        ) u_dut (
            .clk(clk), .rst(rst), .prio(prio),
            .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
            .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
            .ack0(ack0[g]), .ack1(ack1[g]), .rdata0(rdata0[g]), .rdata1(rdata1[g]),
            .busy(busy[g]), .m_addr(m_addr[g]), .m_idata(m_idata[g]),
            .m_csb(m_csb[g]), .m_web(m_web[g]), .m_oeb(m_oeb[g]), .m_ce(m_ce[g]),
            .m_odata(m_odata[g])
        );
        assign m_odata[g] = mem[g][m_addr[g]];
    end

    // Memory controller model: a write lands on every enabled strobe cycle.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (m_ce[i] && !m_csb[i] && !m_web[i]) mem[i][m_addr[i]] = m_idata[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // ph = cycles since the grant edge: 0 idle, 1 setup, 2..S+1 strobe,
    // S+2 release, S+3 done.
    int            ph [NI];
    logic          mown [NI];
    logic          mlast [NI];
    logic          mwr [NI];
    logic [AW-1:0] maddr [NI];
    logic [DW-1:0] mwdata [NI];
    logic [DW-1:0] mrd0 [NI];
    logic [DW-1:0] mrd1 [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ph[i] >= 2 && ph[i] <= sc(i) + 1 && mwr[i]) ref_mem[i][maddr[i]] = mwdata[i];
            if (rst) begin
                ph[i] = 0; mlast[i] = 1'b1; mown[i] = 1'b0; mwr[i] = 1'b0;
                maddr[i] = '0; mwdata[i] = '0; mrd0[i] = '0; mrd1[i] = '0;
            end else if (ph[i] == 0) begin
                if (req0 || req1) begin
                    mown[i]   = (req0 && req1) ? (prio ? 1'b1 : ~mlast[i]) : req1;
                    mlast[i]  = mown[i];
                    mwr[i]    = mown[i] ? wr1 : wr0;
                    maddr[i]  = mown[i] ? addr1 : addr0;
                    mwdata[i] = mown[i] ? wdata1 : wdata0;
                    ph[i]     = 1;
                end
            end else if (ph[i] == sc(i) + 3) begin
                ph[i] = 0;
            end else begin
                if (ph[i] == sc(i) + 2 && !mwr[i]) begin
                    if (mown[i]) mrd1[i] = ref_mem[i][maddr[i]];
                    else         mrd0[i] = ref_mem[i][maddr[i]];
                end
                ph[i] = ph[i] + 1;
            end
        end
    end

    // ---------------- compare process ----------------
    int            cs, cp;
    logic          e_csb, e_web, e_oeb, e_ce, e_a0, e_a1;
    logic [DW-1:0] e_idata;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            cs = sc(i);
            cp = ph[i];
            e_csb = 1'b1; e_web = 1'b1; e_oeb = 1'b1; e_ce = 1'b0;
            e_idata = '0; e_a0 = 1'b0; e_a1 = 1'b0;
            if (cp >= 1 && cp <= cs + 1) begin
                e_csb   = 1'b0;
                e_web   = ~mwr[i];
                e_oeb   = mwr[i];
                e_idata = mwr[i] ? mwdata[i] : '0;
                e_ce    = (cp >= 2);
            end else if (cp == cs + 2) begin
                e_oeb = mwr[i];
            end else if (cp == cs + 3) begin
                e_a0 = ~mown[i];
                e_a1 = mown[i];
            end
            check($sformatf("i%0d m_csb", i), m_csb[i], e_csb);
            check($sformatf("i%0d m_web", i), m_web[i], e_web);
            check($sformatf("i%0d m_oeb", i), m_oeb[i], e_oeb);
            check($sformatf("i%0d m_ce", i), m_ce[i], e_ce);
            check($sformatf("i%0d m_idata", i), m_idata[i], e_idata);
            check($sformatf("i%0d m_addr", i), m_addr[i], maddr[i]);
            check($sformatf("i%0d busy", i), busy[i], cp != 0);
            check($sformatf("i%0d ack0", i), ack0[i], e_a0);
            check($sformatf("i%0d ack1", i), ack1[i], e_a1);
            check($sformatf("i%0d rdata0", i), rdata0[i], mrd0[i]);
            check($sformatf("i%0d rdata1", i), rdata1[i], mrd1[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy[0] || busy[1], 1'b0);
    endtask

    // Counts negedges from the cycle the request is presented to the ack.
    task automatic wait_ack(input int i, input logic port, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(port ? ack1[i] : ack0[i]) && lat < 40);
        check($sformatf("i%0d ack%0d_seen", i, port), port ? ack1[i] : ack0[i], 1'b1);
    endtask

    int            lat;
    int            n0, n1;
    int            t_ack[$];
    int            p_ack[$];
    logic [AW-1:0] alist [11];
    logic [DW-1:0] dlist [11];

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 65536; a++) begin
                mem[i][a]     = '0;
                ref_mem[i][a] = '0;
            end
        end

        // Reset values.
        do_reset();
        check("rst m_csb", m_csb[0], 1'b1);
        check("rst m_ce", m_ce[0], 1'b0);
        check("rst m_oeb", m_oeb[0], 1'b1);
        check("rst m_addr", m_addr[0], 16'h0000);
        check("rst busy", busy[0], 1'b0);
        check("rst rdata1", rdata1[0], 8'h00);

        // Single write on port 0, then read back on port 1 (STROBE_CYC = 1).
        prio = 1'b0; req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0010; wdata0 = 8'hA5;
        @(negedge clk);
        check("wr t+1 m_csb", m_csb[0], 1'b0);
        check("wr t+1 m_web", m_web[0], 1'b0);
        check("wr t+1 m_idata", m_idata[0], 8'hA5);
        @(negedge clk);
        check("wr t+2 m_ce", m_ce[0], 1'b1);
        @(negedge clk);
        check("wr t+3 m_csb", m_csb[0], 1'b1);
        @(negedge clk);
        check("wr t+4 ack0", ack0[0], 1'b1);
        req0 = 1'b0;
        wait_idle();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0010;
        wait_ack(0, 1'b1, lat);
        check("rd latency", lat, 4);
        check("rd rdata1", rdata1[0], 8'hA5);
        req1 = 1'b0;
        wait_idle();

        // Round-robin under continuous contention.
        do_reset();
        prio = 1'b0; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 16'h0010; addr1 = 16'h0020;
        for (int c = 1; c <= 30 && t_ack.size() < 4; c++) begin
            @(negedge clk);
            if (ack0[0] || ack1[0]) begin
                t_ack.push_back(c);
                p_ack.push_back(int'(ack1[0]));
            end
        end
        check("rr ack count", t_ack.size(), 4);
        for (int k = 0; k < t_ack.size(); k++) begin
            check($sformatf("rr port %0d", k), p_ack[k], k % 2);
            if (k == 0) check("rr first ack", t_ack[0], 4);
            else        check($sformatf("rr gap %0d", k), t_ack[k] - t_ack[k-1], 5);
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Fixed priority: port 1 takes every grant.
        do_reset();
        prio = 1'b1; req0 = 1'b1; req1 = 1'b1;
        n0 = 0; n1 = 0;
        repeat (30) begin
            @(negedge clk);
            if (ack0[0]) n0++;
            if (ack1[0]) n1++;
        end
        check("prio ack0 count", n0, 0);
        check("prio ack1 count", n1, 6);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Reset pulse during STROBE aborts the access.
        do_reset();
        prio = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        check("abort in strobe", m_ce[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort m_ce", m_ce[0], 1'b0);
        check("abort m_csb", m_csb[0], 1'b1);
        check("abort ack0", ack0[0], 1'b0);
        check("abort rdata0", rdata0[0], 8'h00);
        wait_ack(0, 1'b0, lat);
        check("after abort latency", lat, 4);
        check("after abort rdata0", rdata0[0], 8'hA5);
        req0 = 1'b0;
        wait_idle();

        // STROBE_CYC = 3 write / read-back sweep including all-ones address.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            alist[k] = (k < 10) ? AW'(k) : 16'hFFFF;
            dlist[k] = DW'($urandom);
        end
        for (int k = 0; k < 11; k++) begin
            wait_idle();
            req0 = 1'b1; wr0 = 1'b1; addr0 = alist[k]; wdata0 = dlist[k];
            wait_ack(1, 1'b0, lat);
            check($sformatf("s3 wr lat %0d", k), lat, 6);
            req0 = 1'b0;
        end
        for (int k = 0; k < 11; k++) begin
            wait_idle();
            req0 = 1'b1; wr0 = 1'b0; addr0 = alist[k];
            wait_ack(1, 1'b0, lat);
            check($sformatf("s3 rd lat %0d", k), lat, 6);
            check($sformatf("s3 rd data %0d", k), rdata0[1], dlist[k]);
            req0 = 1'b0;
        end
        wait_idle();

        // Randomized traffic, checked every cycle by the compare process.
        do_reset();
        repeat (3000) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 149) == 0);
            prio   = ($urandom_range(0, 3) == 0);
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            wr0    = $urandom_range(0, 1) == 1;
            wr1    = $urandom_range(0, 1) == 1;
            addr0  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : AW'($urandom_range(0, 7));
            addr1  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : AW'($urandom_range(0, 7));
            wdata0 = DW'($urandom);
            wdata1 = DW'($urandom);
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter STROBE_CYC, default 1, number of cycles M_CE is held high per access; legal range 1..4.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port PRIO  input  1  0 = round-robin, 1 = port 1 wins all contention.
REQ-007 SHALL have ports REQ0/REQ1  input  1  access request per port.
REQ-008 SHALL have ports WR0/WR1  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports ADDR0/ADDR1  input  ADDR_W  access address.
REQ-010 SHALL have ports WDATA0/WDATA1  input  DATA_W  write data.
REQ-011 SHALL have ports ACK0/ACK1  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports RDATA0/RDATA1  output  DATA_W  read data, valid when ACKn=1.
REQ-013 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-014 SHALL have ports M_ADDR (ADDR_W), M_IDATA (DATA_W), M_CSB, M_WEB, M_OEB, M_CE (1 each)  output  memory controller strobes; CSB/WEB/OEB active-low.
REQ-015 SHALL have port M_ODATA  input  DATA_W  read data from memory controller.

Function
REQ-016 SHALL implement states IDLE, SETUP, STROBE, RELEASE, DONE; all outputs registered.
REQ-017 In IDLE: M_CSB=1, M_WEB=1, M_OEB=1, M_CE=0, M_IDATA=0; M_ADDR holds its last value; no ACK.
REQ-018 In IDLE with any REQn=1: SHALL latch the winner's WR, ADDR, WDATA and owner, and enter SETUP next cycle.
REQ-019 Arbitration with a single requester SHALL grant that requester.
REQ-020 Contention with PRIO=0 SHALL grant the port not granted last; the last-grant pointer SHALL update on every grant.
REQ-021 Contention with PRIO=1 SHALL grant port 1; the pointer SHALL still update.
REQ-022 SETUP (1 cycle): M_CSB=0, M_ADDR=latched addr, M_WEB=~WR, M_OEB=WR, M_IDATA=WDATA if write else 0, M_CE=0.
REQ-023 STROBE (STROBE_CYC cycles, down-counter): SETUP values held, M_CE=1.
REQ-024 RELEASE (1 cycle): M_CE=0, M_CSB=1, M_WEB=1, M_IDATA=0; M_OEB stays 0 for reads, 1 for writes; reads capture M_ODATA into the owner's RDATAn at the end of this cycle.
REQ-025 DONE (1 cycle): ACK of owner=1, other ACK=0; no arbitration; go to IDLE.
REQ-026 Latency: REQ sampled in IDLE at cycle t -> SETUP t+1, STROBE t+2..t+1+STROBE_CYC, RELEASE t+2+STROBE_CYC, ACK t+3+STROBE_CYC.
REQ-027 Requester SHALL hold REQ and command stable until its ACK; commands are latched, so later changes SHALL NOT affect the access in flight.
REQ-028 REQn still high in the IDLE cycle after ACK SHALL be treated as a new request.
REQ-029 RDATAn SHALL hold its value until that port's next read completes; writes SHALL NOT change RDATAn.
REQ-030 ADDR=all-ones SHALL be issued unmodified; no address arithmetic in the block.
REQ-031 ACK0 and ACK1 SHALL never be high in the same cycle.

Reset
REQ-032 RST=1 at a rising edge SHALL force IDLE, M_CSB=1, M_WEB=1, M_OEB=1, M_CE=0, M_ADDR=0, M_IDATA=0, ACK0=ACK1=0, RDATA0=RDATA1=0, BUSY=0, last-grant=port 1, so port 0 wins the first contention.
REQ-033 RST during SETUP, STROBE or RELEASE SHALL abort the access: no ACK, no RDATA update, strobes idle the next cycle.

Verification
REQ-034 Hold RST=1 for 2 cycles, then release -> all outputs at REQ-032 values, BUSY=0.
REQ-035 STROBE_CYC=1, port 0 writes 0xA5 to 0x0010 at cycle t -> t+1 M_CSB=0, M_WEB=0, M_IDATA=0xA5; t+2 M_CE=1; t+3 M_CSB=1; ACK0=1 at t+4. Port 1 then reads 0x0010 -> ACK1 with RDATA1=0xA5.
REQ-036 After reset, PRIO=0, REQ0=REQ1=1 held continuously -> ACKs alternate 0,1,0,1, one ACK every 5 cycles.
REQ-037 PRIO=1, REQ0=REQ1=1 held -> every access granted to port 1; ACK0 never asserts.
REQ-038 RST pulsed for one cycle during STROBE -> next cycle M_CE=0, M_CSB=1, no ACK; the next request completes normally.
REQ-039 STROBE_CYC=3, port 0 writes random data to 0x0000..0x0009 and 0xFFFF, then reads them back -> every RDATA0 matches; each ACK arrives 6 cycles after its request is sampled.
